grava_senha: RTL and testbench
==============================

Name: grava_senha

Overview:
Password programming block; the writer-side counterpart of the password checker. It captures a new button sequence of LEN presses from b1..b4 and requires the user to enter the same sequence a second time. Only after a matching confirmation does it commit the sequence to the `senha` register. A configurable checker reads `senha`, and a status LED reads the pulse outputs.

Parameters:
LEN, 4, number of digits in the password (2..8).
TIMEOUT, 50_000_000, idle cycles allowed between presses during capture/confirm before abort (≥2).

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
prog  in  1  request to start programming; level, acted on when sampled high in IDLE
b1  in  1  button 1, active-high level, already debounced
b2  in  1  button 2
b3  in  1  button 3
b4  in  1  button 4
senha  out  2*LEN  committed password; digit k in bits [2k+1:2k]; code 0..3 = b1..b4
gravando  out  1  high while in CAPTURE or CONFIRM
gravou  out  1  one-cycle pulse: new password committed
errou  out  1  one-cycle pulse: confirmation mismatch, invalid press, or timeout

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-high on `reset`. Every state and output register updates only on posedge clk.
- Reset values: state=IDLE; senha = default {3,2,1,0} for LEN=4, i.e. digit k = k mod 4; gravando=0; gravou=0; errou=0; digit counter=0; timer=0; temp buffer=0.
- Press event:
  - `any` = b1|b2|b3|b4. Register `any_q` each cycle.
  - An event occurs in cycle t when any(t)=1 and any_q(t)=0.
  - Valid event: exactly one button high; its code is 0..3.
  - Invalid event: two or more buttons high.
  - Held buttons produce no further events. Release is required between digits.
- FSM states: IDLE, CAPTURE, CONFIRM.
  - IDLE:
    - prog=1 → CAPTURE; counter=0; timer=0.
    - Presses are ignored in IDLE.
  - CAPTURE:
    - Valid event → temp[counter]=code; counter++; timer=0.
    - When counter reaches LEN-1 and a valid event occurs → CONFIRM; counter=0.
  - CONFIRM:
    - Valid event whose code equals temp[counter] → counter++; timer=0.
    - Last digit matches → senha←temp and gravou=1 in the same registered update; state goes to IDLE.
    - Code differs → errou=1; state goes to IDLE; senha unchanged.
  - Invalid event in CAPTURE or CONFIRM → errou=1; state goes to IDLE.
  - Timeout in CAPTURE or CONFIRM:
    - Timer increments each cycle with no event.
    - Timer == TIMEOUT-1 with no event → errou=1; state goes to IDLE; senha unchanged.
    - An event in that same cycle takes priority over the timeout.
- Other rules:
  - prog while gravando=1 is ignored; it does not restart programming.
  - Outputs are registered. gravou/errou assert on the edge after the deciding event, so latency from the event cycle is 1 clk. Each pulse lasts exactly 1 cycle. gravou and errou are never high together.
  - gravando is high in every cycle the state is CAPTURE or CONFIRM.
  - Reset mid-operation: aborts with no pulse; senha returns to its default.
  - senha changes only on commit or reset.

Decomposition:
- Package `senha_pkg` contains:
  - state enum: IDLE=2'd0, CAPTURE=2'd1, CONFIRM=2'd2;
  - digit width constant DIG_W=2;
  - function default_senha(LEN);
  - button-code constants B1..B4=0..3.
- Sub-module `detecta_botao` holds the any_q register, event/valid/code generation, and one-hot validity check. Inputs: clk, reset, b1..b4. Outputs: evento, valido, codigo[1:0].

Test Plan:
- Commit: reset; prog=1 for 1 cycle; press b2,b4,b1,b3 (each 3 cycles high, 2 low); repeat the same → gravou pulses 1 cycle after the 8th press; senha=8'b10_00_11_01 (digits 1,3,0,2); errou never high.
- Mismatch: program b1,b1,b1,b1; confirm b1,b1,b2 → errou at 3rd confirm press+1; gravando=0; senha stays the default 8'b11_10_01_00.
- Invalid press: in CAPTURE, press b1+b3 together → errou pulse; state IDLE; senha unchanged.
- Held button: hold b3 for 20 cycles in CAPTURE → counts as one digit. Then b3,b3,b3 → CONFIRM entered after 4 total presses, not earlier.
- Timeout (TIMEOUT=10): prog, then one press, then idle → errou exactly 10 cycles after the press; gravando falls at the same edge.
- Reset mid-confirm and prog while busy: assert reset during CONFIRM → all outputs 0 and senha=default next cycle, no pulses. Pulsing prog during CAPTURE → digit counter is not cleared.

Source files
------------

// File: rtl/senha_pkg.sv
// Shared types and constants for the password programming block.
package senha_pkg;

  localparam int unsigned DIG_W   = 2;
  localparam int unsigned MAX_LEN = 8;

  localparam logic [DIG_W-1:0] B1 = 2'd0;
  localparam logic [DIG_W-1:0] B2 = 2'd1;
  localparam logic [DIG_W-1:0] B3 = 2'd2;
  localparam logic [DIG_W-1:0] B4 = 2'd3;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CAPTURE = 2'd1,
    CONFIRM = 2'd2
  } estado_t;

  // Factory password: digit k holds code k mod 4, unused upper digits are zero.
  function automatic logic [DIG_W*MAX_LEN-1:0] default_senha(input int unsigned len);
    logic [DIG_W*MAX_LEN-1:0] v;
    v = '0;
    for (int unsigned k = 0; k < MAX_LEN; k++) begin
      if (k < len) v[DIG_W*k +: DIG_W] = DIG_W'(k % 4);
    end
    return v;
  endfunction

endpackage

// File: rtl/detecta_botao.sv
// Press-edge detector: flags a new press, whether it is a single button, and its code.
module detecta_botao
  import senha_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             b1,
  input  logic             b2,
  input  logic             b3,
  input  logic             b4,
  output logic             evento,
  output logic             valido,
  output logic [DIG_W-1:0] codigo
);

  logic [3:0] w_botoes;
  logic       w_any;
  logic       w_one_hot;
  logic       r_any_q;

  assign w_botoes  = {b4, b3, b2, b1};
  assign w_any     = |w_botoes;
  assign w_one_hot = w_any && ((w_botoes & (w_botoes - 4'd1)) == 4'd0);

  always_ff @(posedge clk) begin
    if (reset) r_any_q <= 1'b0;
    else       r_any_q <= w_any;
  end

  // Only the rising edge of "any button" counts; held buttons stay silent.
  assign evento = w_any & ~r_any_q;
  assign valido = evento & w_one_hot;

  always_comb begin
    codigo = B1;
    case (w_botoes)
      4'b0010: codigo = B2;
      4'b0100: codigo = B3;
      4'b1000: codigo = B4;
      default: codigo = B1;
    endcase
  end

endmodule

// File: rtl/grava_senha.sv
// Password programming: capture a sequence, require an identical confirmation, then commit.
module grava_senha
  import senha_pkg::*;
#(
  parameter int unsigned LEN     = 4,
  parameter int unsigned TIMEOUT = 50_000_000
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 prog,
  input  logic                 b1,
  input  logic                 b2,
  input  logic                 b3,
  input  logic                 b4,
  output logic [DIG_W*LEN-1:0] senha,
  output logic                 gravando,
  output logic                 gravou,
  output logic                 errou
);

  localparam int unsigned SENHA_W = DIG_W * LEN;
  localparam int unsigned CNT_W   = $clog2(LEN);
  localparam int unsigned TMR_W   = $clog2(TIMEOUT);

  localparam logic [DIG_W*MAX_LEN-1:0] DEF_FULL  = default_senha(LEN);
  localparam logic [SENHA_W-1:0]       DEF_SENHA = DEF_FULL[SENHA_W-1:0];

  logic             w_evento;
  logic             w_valido;
  logic [DIG_W-1:0] w_codigo;

  estado_t          r_estado,   w_estado_nx;
  logic [CNT_W-1:0] r_cnt,      w_cnt_nx;
  logic [TMR_W-1:0] r_timer,    w_timer_nx;
  logic [SENHA_W-1:0] r_temp,   w_temp_nx;
  logic [SENHA_W-1:0] r_senha,  w_senha_nx;
  logic             r_gravando;
  logic             r_gravou,   w_gravou_nx;
  logic             r_errou,    w_errou_nx;
  logic [DIG_W-1:0] w_digito_esp;
  logic             w_ultimo;
  logic             w_expirou;

  detecta_botao u_detecta (
    .clk    (clk),
    .reset  (reset),
    .b1     (b1),
    .b2     (b2),
    .b3     (b3),
    .b4     (b4),
    .evento (w_evento),
    .valido (w_valido),
    .codigo (w_codigo)
  );

  assign w_digito_esp = r_temp[DIG_W*r_cnt +: DIG_W];
  assign w_ultimo     = (r_cnt == CNT_W'(LEN - 1));
  assign w_expirou    = (r_timer == TMR_W'(TIMEOUT - 1));

  always_ff @(posedge clk) begin
    if (reset) begin
      r_estado   <= IDLE;
      r_cnt      <= '0;
      r_timer    <= '0;
      r_temp     <= '0;
      r_senha    <= DEF_SENHA;
      r_gravando <= 1'b0;
      r_gravou   <= 1'b0;
      r_errou    <= 1'b0;
    end else begin
      r_estado   <= w_estado_nx;
      r_cnt      <= w_cnt_nx;
      r_timer    <= w_timer_nx;
      r_temp     <= w_temp_nx;
      r_senha    <= w_senha_nx;
      r_gravando <= (w_estado_nx != IDLE);
      r_gravou   <= w_gravou_nx;
      r_errou    <= w_errou_nx;
    end
  end

  // Next-state logic; a press in the timeout cycle wins over the timeout.
  always_comb begin
    w_estado_nx = r_estado;
    w_cnt_nx    = r_cnt;
    w_timer_nx  = r_timer;
    w_temp_nx   = r_temp;
    w_senha_nx  = r_senha;
    w_gravou_nx = 1'b0;
    w_errou_nx  = 1'b0;

    case (r_estado)
      IDLE: begin
        if (prog) begin
          w_estado_nx = CAPTURE;
          w_cnt_nx    = '0;
          w_timer_nx  = '0;
        end
      end

      CAPTURE: begin
        if (w_evento) begin
          if (w_valido) begin
            w_temp_nx[DIG_W*r_cnt +: DIG_W] = w_codigo;
            w_timer_nx = '0;
            if (w_ultimo) begin
              w_estado_nx = CONFIRM;
              w_cnt_nx    = '0;
            end else begin
              w_cnt_nx = r_cnt + CNT_W'(1);
            end
          end else begin
            w_estado_nx = IDLE;
            w_errou_nx  = 1'b1;
          end
        end else if (w_expirou) begin
          w_estado_nx = IDLE;
          w_errou_nx  = 1'b1;
        end else begin
          w_timer_nx = r_timer + TMR_W'(1);
        end
      end

      CONFIRM: begin
        if (w_evento) begin
          if (w_valido && (w_codigo == w_digito_esp)) begin
            w_timer_nx = '0;
            if (w_ultimo) begin
              w_estado_nx = IDLE;
              w_senha_nx  = r_temp;
              w_gravou_nx = 1'b1;
            end else begin
              w_cnt_nx = r_cnt + CNT_W'(1);
            end
          end else begin
            w_estado_nx = IDLE;
            w_errou_nx  = 1'b1;
          end
        end else if (w_expirou) begin
          w_estado_nx = IDLE;
          w_errou_nx  = 1'b1;
        end else begin
          w_timer_nx = r_timer + TMR_W'(1);
        end
      end

      default: w_estado_nx = IDLE;
    endcase

    if (w_estado_nx == IDLE && r_estado != IDLE) begin
      w_cnt_nx   = '0;
      w_timer_nx = '0;
    end
  end

  assign senha    = r_senha;
  assign gravando = r_gravando;
  assign gravou   = r_gravou;
  assign errou    = r_errou;

endmodule

// File: tb/tb_grava_senha.sv
// Scoreboard bench for grava_senha: expected pulses are queued at stimulus time and matched by a monitor.
module tb_grava_senha;

  localparam int unsigned TB_LEN = 4;
  localparam int unsigned TB_T   = 24;
  localparam logic [7:0]  DEF    = 8'hE4;

  typedef struct {
    int         kind;
    int         cyc;
    logic [7:0] senha;
  } exp_t;

  logic       clk = 1'b0;
  logic       reset, prog, b1, b2, b3, b4;
  logic [7:0] senha;
  logic       gravando, gravou, errou;

  int   cyc = 0;
  int   checks = 0;
  int   failures = 0;
  exp_t q[$];

  grava_senha #(.LEN(TB_LEN), .TIMEOUT(TB_T)) dut (
    .clk      (clk),
    .reset    (reset),
    .prog     (prog),
    .b1       (b1),
    .b2       (b2),
    .b3       (b3),
    .b4       (b4),
    .senha    (senha),
    .gravando (gravando),
    .gravou   (gravou),
    .errou    (errou)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // kind: 0 none, 1 gravou, 2 errou; pulse expected 1 + dly cycles after the event edge.
  task automatic press(input logic [3:0] b, input int hi, input int kind, input int dly,
                       input logic [7:0] sen);
    exp_t e;
    {b4, b3, b2, b1} = b;
    if (kind != 0) begin
      e.kind  = kind;
      e.cyc   = cyc + 1 + dly;
      e.senha = sen;
      q.push_back(e);
    end
    repeat (hi) begin @(posedge clk); #1; end
    {b4, b3, b2, b1} = 4'b0000;
    repeat (2) begin @(posedge clk); #1; end
  endtask

  task automatic pulse_prog();
    prog = 1'b1;
    @(posedge clk); #1;
    prog = 1'b0;
  endtask

  task automatic pulse_reset();
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  // Monitor: every gravou/errou pulse must match the head of the queue.
  always @(negedge clk) begin
    exp_t e;
    if (gravou || errou) begin
      if (q.size() == 0) begin
        chk("unexpected_pulse", {30'd0, errou, gravou}, 32'd0);
      end else begin
        e = q.pop_front();
        chk("pulse_kind", {30'd0, errou, gravou}, e.kind);
        chk("pulse_cycle", cyc, e.cyc);
        chk("pulse_senha", {24'd0, senha}, {24'd0, e.senha});
        chk("pulse_gravando", {31'd0, gravando}, 32'd0);
      end
    end
  end

  initial begin
    logic [3:0] seq[4];
    int guard;
    seq = '{4'b0010, 4'b1000, 4'b0001, 4'b0100};
    reset = 1'b1; prog = 1'b0;
    {b4, b3, b2, b1} = 4'b0000;
    idle(3);
    reset = 1'b0;
    chk("rst_senha", {24'd0, senha}, {24'd0, DEF});
    chk("rst_gravando", {31'd0, gravando}, 32'd0);
    chk("rst_gravou", {31'd0, gravou}, 32'd0);
    chk("rst_errou", {31'd0, errou}, 32'd0);

    // Presses in IDLE are ignored
    press(4'b0001, 3, 0, 0, 8'h00);
    chk("idle_gravando", {31'd0, gravando}, 32'd0);

    // Commit b2,b4,b1,b3 -> digits 1,3,0,2
    pulse_prog();
    chk("prog_gravando", {31'd0, gravando}, 32'd1);
    for (int i = 0; i < 4; i++) press(seq[i], 3, 0, 0, 8'h00);
    chk("capture_gravando", {31'd0, gravando}, 32'd1);
    for (int i = 0; i < 4; i++) press(seq[i], 3, (i == 3) ? 1 : 0, 0, 8'h8D);
    idle(3);
    chk("commit_senha", {24'd0, senha}, 32'h8D);
    chk("commit_gravando", {31'd0, gravando}, 32'd0);

    pulse_reset();
    chk("reset_senha", {24'd0, senha}, {24'd0, DEF});

    // Mismatch on third confirm digit
    pulse_prog();
    for (int i = 0; i < 4; i++) press(4'b0001, 3, 0, 0, 8'h00);
    press(4'b0001, 3, 0, 0, 8'h00);
    press(4'b0001, 3, 0, 0, 8'h00);
    press(4'b0010, 3, 2, 0, DEF);
    idle(3);
    chk("mismatch_senha", {24'd0, senha}, {24'd0, DEF});
    chk("mismatch_gravando", {31'd0, gravando}, 32'd0);

    // Invalid double press in CAPTURE
    pulse_prog();
    press(4'b0001, 3, 0, 0, 8'h00);
    press(4'b0101, 3, 2, 0, DEF);
    idle(3);
    chk("invalid_senha", {24'd0, senha}, {24'd0, DEF});

    // Held button counts once
    pulse_prog();
    press(4'b0100, 20, 0, 0, 8'h00);
    for (int i = 0; i < 3; i++) press(4'b0100, 3, 0, 0, 8'h00);
    for (int i = 0; i < 4; i++) press(4'b0100, 3, (i == 3) ? 1 : 0, 0, 8'hAA);
    idle(3);
    chk("held_senha", {24'd0, senha}, 32'hAA);

    // Timeout after one press
    pulse_prog();
    press(4'b1000, 3, 2, TB_T, 8'hAA);
    chk("timeout_pending_gravando", {31'd0, gravando}, 32'd1);
    idle(30);
    chk("timeout_gravando", {31'd0, gravando}, 32'd0);
    chk("timeout_senha", {24'd0, senha}, 32'hAA);

    // prog while busy does not restart the digit counter
    pulse_prog();
    press(4'b0010, 3, 0, 0, 8'h00);
    pulse_prog();
    chk("busy_prog_gravando", {31'd0, gravando}, 32'd1);
    for (int i = 0; i < 3; i++) press(4'b0010, 3, 0, 0, 8'h00);
    for (int i = 0; i < 4; i++) press(4'b0010, 3, (i == 3) ? 1 : 0, 0, 8'h55);
    idle(3);
    chk("busy_senha", {24'd0, senha}, 32'h55);

    // Reset in the middle of CONFIRM
    pulse_prog();
    for (int i = 0; i < 4; i++) press(4'b0001, 3, 0, 0, 8'h00);
    press(4'b0001, 3, 0, 0, 8'h00);
    pulse_reset();
    chk("midrst_senha", {24'd0, senha}, {24'd0, DEF});
    chk("midrst_gravando", {31'd0, gravando}, 32'd0);
    chk("midrst_gravou", {31'd0, gravou}, 32'd0);
    chk("midrst_errou", {31'd0, errou}, 32'd0);
    idle(5);

    guard = 0;
    while (q.size() != 0 && guard < 200) begin
      @(posedge clk); #1;
      guard++;
    end
    chk("queue_drained", q.size(), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
